// File: rtl/misc_pipe_if.sv
// misc_pipe_if: operand/result stream bundle for misc_pipe
interface misc_pipe_if #(
    parameter int NA   = 8,
    parameter int NB   = 4,
    parameter int ACCW = 16
);
    logic            IN_VALID;
    logic            IN_READY;
    logic [NA-1:0]   A;
    logic [NB-1:0]   B;
    logic [NA-1:0]   C;
    logic            ACC_EN;
    logic            ACC_CLR;
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [NA-1:0]   XOUT1;
    logic [NA-1:0]   XOUT2;
    logic [ACCW-1:0] ACC;
    modport slave (
        input  IN_VALID, A, B, C, ACC_EN, ACC_CLR, OUT_READY,
        output IN_READY, OUT_VALID, XOUT1, XOUT2, ACC
    );
    modport master (
        output IN_VALID, A, B, C, ACC_EN, ACC_CLR, OUT_READY,
        input  IN_READY, OUT_VALID, XOUT1, XOUT2, ACC
    );
endinterface

// File: rtl/misc_pipe.sv
// misc_pipe: 3-stage pipelined Misc datapath with stall flow control and XOUT1 accumulator
module misc_pipe #(
    parameter int NA   = 8,
    parameter int NB   = 4,
    parameter int ACCW = 16
) (
    input logic       CLK,
    input logic       RST,
    misc_pipe_if.slave bus
);
    localparam logic [NA-1:0] MAGIC = {1'b0, {(NA-1){1'b1}}};
    logic          adv;
    logic [NA-1:0] bx, nb_c, na_c, br_c, t1_c;
    logic [NA-1:0] d0_c, d1_c, p_c, q_c, zz_c, x1_c, x2_c;
    logic          s1_v, s1_en, s2_v, s2_en, out_en;
    logic [NA-1:0] s1_a, s1_bx, s1_c, s1_na, s1_nb, s1_br, s1_t1;
    logic [NA-1:0] s2_a, s2_bx, s2_c, s2_na, s2_d0, s2_d1, s2_p, s2_q;
    assign adv          = !bus.OUT_VALID || bus.OUT_READY;
    assign bus.IN_READY = adv;
    // stage-1 sum/difference and first branch select from the raw operands
    always_comb begin
        bx   = NA'(bus.B);
        nb_c = bus.A + bx;
        na_c = bus.A - bx;
        br_c = (bus.A > bx) ? nb_c : na_c;
        t1_c = (bus.A > bx) ? bus.A : nb_c;
    end
    // stage-2 nested branch select, product and weighted sum
    always_comb begin
        d0_c = (s1_br > s1_t1) ? s1_br + s1_t1 : s1_br - s1_t1;
        d1_c = (s1_br > s1_t1) ? s1_br : s1_br + s1_t1;
        p_c  = s1_na * s1_nb;
        q_c  = s1_na + s1_nb * NA'(3);
    end
    // stage-3 final results; the magic A value swaps in A*bx as the product term
    always_comb begin
        zz_c = (s2_a == MAGIC) ? s2_a * s2_bx : s2_d0 * s2_d1;
        x1_c = s2_na - ((s2_p - NA'(1)) - s2_q) + zz_c;
        x2_c = s2_na + s2_c + NA'(5);
    end
    // pipeline registers: whole pipe shifts together on adv, holds otherwise
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_v          <= 1'b0;
            s2_v          <= 1'b0;
            bus.OUT_VALID <= 1'b0;
            bus.XOUT1     <= '0;
            bus.XOUT2     <= '0;
        end else if (adv) begin
            s1_v          <= bus.IN_VALID;
            s1_en         <= bus.ACC_EN;
            s1_a          <= bus.A;
            s1_bx         <= bx;
            s1_c          <= bus.C;
            s1_na         <= na_c;
            s1_nb         <= nb_c;
            s1_br         <= br_c;
            s1_t1         <= t1_c;
            s2_v          <= s1_v;
            s2_en         <= s1_en;
            s2_a          <= s1_a;
            s2_bx         <= s1_bx;
            s2_c          <= s1_c;
            s2_na         <= s1_na;
            s2_d0         <= d0_c;
            s2_d1         <= d1_c;
            s2_p          <= p_c;
            s2_q          <= q_c;
            bus.OUT_VALID <= s2_v;
            out_en        <= s2_en;
            bus.XOUT1     <= x1_c;
            bus.XOUT2     <= x2_c;
        end
    end
    // accumulate XOUT1 on handshakes of enabled beats; clear wins over a same-cycle add
    always_ff @(posedge CLK) begin
        if (RST || bus.ACC_CLR)
            bus.ACC <= '0;
        else if (bus.OUT_VALID && bus.OUT_READY && out_en)
            bus.ACC <= bus.ACC + ACCW'(bus.XOUT1);
    end
endmodule

// File: tb/tb_misc_pipe.sv
// tb_misc_pipe: directed self-checking bench for misc_pipe
module tb_misc_pipe;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   tests = 0;
    int   fails = 0;

    misc_pipe_if #(.NA(8), .NB(4), .ACCW(16)) bus();
    misc_pipe #(.NA(8), .NB(4), .ACCW(16)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [7:0] a, input logic [3:0] b, input logic [7:0] c, input logic en);
        bus.IN_VALID = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.C        = c;
        bus.ACC_EN   = en;
    endtask

    task automatic idle();
        bus.IN_VALID = 1'b0;
        bus.ACC_EN   = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] x1, input logic [7:0] x2);
        chk({tag, "_ov"}, 32'(bus.OUT_VALID), 32'd1);
        chk({tag, "_x1"}, 32'(bus.XOUT1), 32'(x1));
        chk({tag, "_x2"}, 32'(bus.XOUT2), 32'(x2));
    endtask

    initial begin
        bus.IN_VALID  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.C         = '0;
        bus.ACC_EN    = 1'b0;
        bus.ACC_CLR   = 1'b0;
        bus.OUT_READY = 1'b1;
        tick(2);
        chk("rst_ov", 32'(bus.OUT_VALID), 32'd0);
        chk("rst_x1", 32'(bus.XOUT1), 32'd0);
        chk("rst_x2", 32'(bus.XOUT2), 32'd0);
        chk("rst_acc", 32'(bus.ACC), 32'd0);
        chk("rst_in_ready", 32'(bus.IN_READY), 32'd1);
        RST = 1'b0;

        beat(8'd10, 4'd3, 8'h20, 1'b1);
        tick();
        idle();
        tick();
        chk("lat_early_ov", 32'(bus.OUT_VALID), 32'd0);
        tick();
        chk_out("basic", 8'd6, 8'd44);
        chk("basic_acc_pre", 32'(bus.ACC), 32'd0);
        tick();
        chk("basic_acc", 32'(bus.ACC), 32'd6);
        chk("basic_ov_after", 32'(bus.OUT_VALID), 32'd0);

        bus.ACC_CLR = 1'b1;
        tick();
        bus.ACC_CLR = 1'b0;
        chk("clr_idle_acc", 32'(bus.ACC), 32'd0);

        beat(8'd10, 4'd3, 8'h20, 1'b1);
        tick();
        beat(8'd127, 4'd2, 8'h00, 1'b1);
        tick();
        beat(8'd2, 4'd5, 8'hFF, 1'b1);
        tick();
        idle();
        bus.OUT_READY = 1'b0;
        #1;
        chk_out("b2b_first", 8'd6, 8'd44);
        chk("b2b_in_ready", 32'(bus.IN_READY), 32'd0);
        repeat (4) begin
            tick();
            chk_out("stall", 8'd6, 8'd44);
            chk("stall_in_ready", 32'(bus.IN_READY), 32'd0);
            chk("stall_acc", 32'(bus.ACC), 32'd0);
        end
        bus.OUT_READY = 1'b1;
        #1;
        chk("release_in_ready", 32'(bus.IN_READY), 32'd1);
        tick();
        chk_out("magic", 8'd127, 8'd130);
        chk("acc_after1", 32'(bus.ACC), 32'd6);
        tick();
        chk_out("wrap", 8'd25, 8'd1);
        chk("acc_after2", 32'(bus.ACC), 32'd133);
        tick();
        chk("drain_ov", 32'(bus.OUT_VALID), 32'd0);
        chk("acc_after3", 32'(bus.ACC), 32'd158);
        tick();
        chk("nodup_ov", 32'(bus.OUT_VALID), 32'd0);
        chk("nodup_acc", 32'(bus.ACC), 32'd158);

        beat(8'd10, 4'd3, 8'h20, 1'b1);
        tick();
        idle();
        tick(2);
        chk_out("clr_beat", 8'd6, 8'd44);
        bus.ACC_CLR = 1'b1;
        tick();
        bus.ACC_CLR = 1'b0;
        chk("clr_hs_acc", 32'(bus.ACC), 32'd0);
        chk("clr_hs_ov", 32'(bus.OUT_VALID), 32'd0);
        beat(8'd10, 4'd3, 8'h20, 1'b1);
        tick();
        idle();
        tick(3);
        chk("post_clr_acc", 32'(bus.ACC), 32'd6);

        beat(8'd127, 4'd2, 8'h00, 1'b0);
        tick();
        idle();
        tick(2);
        chk_out("noacc_beat", 8'd127, 8'd130);
        tick();
        chk("noacc_acc", 32'(bus.ACC), 32'd6);

        beat(8'd10, 4'd3, 8'h20, 1'b1);
        tick();
        beat(8'd2, 4'd5, 8'hFF, 1'b1);
        tick();
        idle();
        RST = 1'b1;
        tick();
        chk("midrst_ov", 32'(bus.OUT_VALID), 32'd0);
        chk("midrst_acc", 32'(bus.ACC), 32'd0);
        RST = 1'b0;
        repeat (4) begin
            tick();
            chk("midrst_flush_ov", 32'(bus.OUT_VALID), 32'd0);
        end
        chk("midrst_flush_acc", 32'(bus.ACC), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
